rr_arbiter_lock: RTL and testbench
==================================

# rr_arbiter_lock

Parametrised round-robin arbiter with grant locking and an optional hold-time limit. It serves N requesters sharing one resource (bus port, memory bank, output channel). Priority rotates by building a thermometer mask from the last granted index: every bit strictly above the previous winner is set, and that mask is applied to the request vector. The grant is registered, one-hot, and held while the owner keeps requesting, up to MAX_HOLD cycles.

## Interface
- N, 8: number of requesters, ≥2.
- MAX_HOLD, 0: maximum consecutive grant cycles per owner while others wait. 0 means unlimited.
- IW, $clog2(N): index width (derived, not overridden).

- clk  input  1  rising-edge clock, single domain.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i high = requester i wants the resource.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  high when any gnt bit is set.
- gnt_idx  output  IW  binary index of the gnt bit; holds the last winner when idle.

## Operation
- State registers:
  - gnt
  - gnt_valid
  - last_idx: the rotation pointer
  - hold_cnt: IW-independent width, clog2(MAX_HOLD+1) bits, min 1
- mask[i] is 1 for every i > last_idx. It is built as the prefix-OR of onehot(last_idx), shifted up by one; bit 0 is always 0.
- Candidate selection:
  - If (req & mask) is non-zero, the winner is its lowest set bit.
  - Otherwise the winner is the lowest set bit of req.
  - If req is zero, there is no winner.
- Decision on each rising edge, in priority order:
  1. Hold: gnt_valid && req[gnt_idx] && !expire. Keep gnt and increment hold_cnt, saturating.
  2. Re-arbitrate: a winner exists. Load gnt = onehot(winner), gnt_idx = winner, last_idx = winner, hold_cnt = 1.
  3. Idle: no winner. Clear gnt and gnt_valid, clear hold_cnt, keep last_idx and gnt_idx.
- expire = (MAX_HOLD != 0) && (hold_cnt >= MAX_HOLD) && ((req & ~gnt) != 0). An owner alone on the bus is never preempted.
- When expire fires, re-arbitration uses the mask from the current owner. The next winner is therefore always a different requester.
- Only one gnt bit is ever set. gnt is always a subset of the req sampled on the previous edge.

## Timing
- Reset, asynchronous:
  - gnt = 0, gnt_valid = 0, gnt_idx = 0, hold_cnt = 0.
  - last_idx = N-1, so the mask is all-zero and the first search starts at bit 0.
- Latency: req rising in cycle t gives gnt visible after edge t+1. There is no combinational path from req to gnt.
- Handover without a bubble: if the owner drops req in cycle t while another request is pending, the new grant appears at the next edge. gnt is never zero for a cycle in between.
- Owner drop with no other request: gnt goes to 0 at the next edge.
- Simultaneous owner drop and expire: treated as re-arbitration; the result is identical.
- Pointer wrap: last_idx = N-1 gives an empty mask, so the search falls back to the lowest set bit.
- Reset asserted mid-grant: outputs clear immediately and asynchronously. After deassertion, the first grant starts from bit 0.
- Requests that are not granted are not latched. A requester that drops req before it is granted is forgotten.

## Test plan
All scenarios use N=4.
- Reset, then req=4'b1111 held, MAX_HOLD=0:
  - gnt=0001 one cycle after reset release.
  - Held indefinitely, and gnt_idx=0.
- Rotation, MAX_HOLD=0:
  - req=1111, and each owner drops its bit for 1 cycle after 2 grant cycles, then reasserts.
  - Grant order is 0001, 0010, 0100, 1000, 0001, with no gnt=0 cycle between owners.
- Hold limit, MAX_HOLD=3:
  - req=0101 held constant.
  - gnt alternates 0001 ×3 cycles, 0100 ×3 cycles, 0001 ×3 cycles.
- Sole owner, MAX_HOLD=3:
  - req=0010 for 10 cycles.
  - gnt=0010 for all 10 cycles (no preemption).
  - Then req=0 gives gnt=0 and gnt_valid=0 on the next edge, with gnt_idx still 1.
- Wrap and mask:
  - After a grant to idx 3, apply req=0110.
  - gnt=0010 (wrap to lowest). Then 0100 after idx 1 drops.
- Async reset mid-grant:
  - With gnt=0100, assert rst between edges.
  - gnt=0 immediately.
  - After release with req=1100, gnt=0100 (pointer reset, lowest first).

Source files
------------

// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock: round-robin arbiter with grant locking
// and an optional per-owner hold-time limit.
module rr_arbiter_lock #(
  parameter int N = 8,
  parameter int MAX_HOLD = 0,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  localparam int HW =
    (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HLIM = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HSAT = '1;
  localparam logic [HW-1:0] HONE = HW'(1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] last_idx;
  logic [HW-1:0] hold_cnt;

  logic [N-1:0]  last_oh;
  logic [N-1:0]  prefix;
  logic [N-1:0]  mask;
  logic [N-1:0]  masked;
  logic [IW-1:0] win_idx;
  logic          expire;
  logic          hold;

  logic [N-1:0]  gnt_n;
  logic          gnt_valid_n;
  logic [IW-1:0] gnt_idx_n;
  logic [IW-1:0] last_idx_n;
  logic [HW-1:0] hold_cnt_n;

  function automatic logic [IW-1:0] lowest(
    input logic [N-1:0] v
  );
    logic [IW-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  // thermometer mask: every bit strictly above last winner
  always_comb begin
    logic acc;
    last_oh = '0;
    last_oh[last_idx] = 1'b1;
    acc = 1'b0;
    prefix = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc | last_oh[i];
      prefix[i] = acc;
    end
    mask = {prefix[N-2:0], 1'b0};
  end

  // candidate pick: masked requests first, then wrap
  always_comb begin
    masked = req & mask;
    if (|masked) win_idx = lowest(masked);
    else         win_idx = lowest(req);
  end

  // lock/expire decision; lone owner is never preempted
  always_comb begin
    expire = (MAX_HOLD != 0)
           && (hold_cnt >= HLIM)
           && (|(req & ~gnt));
    hold = gnt_valid && (|(req & gnt)) && !expire;
  end

  // next-state: hold, re-arbitrate, or go idle
  always_comb begin
    gnt_n       = gnt;
    gnt_valid_n = gnt_valid;
    gnt_idx_n   = gnt_idx;
    last_idx_n  = last_idx;
    hold_cnt_n  = hold_cnt;
    if (hold) begin
      if (hold_cnt != HSAT) hold_cnt_n = hold_cnt + 1'b1;
    end else if (|req) begin
      gnt_n          = '0;
      gnt_n[win_idx] = 1'b1;
      gnt_valid_n    = 1'b1;
      gnt_idx_n      = win_idx;
      last_idx_n     = win_idx;
      hold_cnt_n     = HONE;
    end else begin
      gnt_n       = '0;
      gnt_valid_n = 1'b0;
      hold_cnt_n  = '0;
    end
  end

  // state registers; pointer resets to top so bit 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      last_idx  <= LAST;
      hold_cnt  <= '0;
    end else begin
      gnt       <= gnt_n;
      gnt_valid <= gnt_valid_n;
      gnt_idx   <= gnt_idx_n;
      last_idx  <= last_idx_n;
      hold_cnt  <= hold_cnt_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// tb_rr_arbiter_lock: directed checks of rr_arbiter_lock
// with N=4, one instance unlimited and one MAX_HOLD=3.
module tb_rr_arbiter_lock;

  logic       clk;
  logic       rst;
  logic [3:0] reqa, gnta;
  logic       va;
  logic [1:0] ia;
  logic [3:0] reqb, gntb;
  logic       vb;
  logic [1:0] ib;

  int ncmp = 0;
  int nerr = 0;

  rr_arbiter_lock #(.N(4), .MAX_HOLD(0)) u_a (
    .clk(clk), .rst(rst), .req(reqa),
    .gnt(gnta), .gnt_valid(va), .gnt_idx(ia)
  );

  rr_arbiter_lock #(.N(4), .MAX_HOLD(3)) u_b (
    .clk(clk), .rst(rst), .req(reqb),
    .gnt(gntb), .gnt_valid(vb), .gnt_idx(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  logic [3:0] seq_h [9];

  initial begin
    rst  = 1'b1;
    reqa = 4'b0000;
    reqb = 4'b0000;
    tick();
    chk("rst_gnt", 32'(gnta), 32'h0);
    chk("rst_valid", 32'(va), 32'h0);
    chk("rst_idx", 32'(ia), 32'h0);

    // first grant and unlimited hold
    reqa = 4'b1111;
    rst  = 1'b0;
    tick();
    chk("first_gnt", 32'(gnta), 32'h1);
    chk("first_valid", 32'(va), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_gnt", 32'(gnta), 32'h1);
      chk("hold_idx", 32'(ia), 32'h0);
    end

    // rotation without bubbles
    reqa = 4'b1110; tick();
    chk("rot1", 32'(gnta), 32'h2);
    reqa = 4'b1111; tick();
    chk("rot1_hold", 32'(gnta), 32'h2);
    reqa = 4'b1101; tick();
    chk("rot2", 32'(gnta), 32'h4);
    reqa = 4'b1111; tick();
    chk("rot2_hold", 32'(gnta), 32'h4);
    reqa = 4'b1011; tick();
    chk("rot3", 32'(gnta), 32'h8);
    chk("rot3_idx", 32'(ia), 32'h3);
    reqa = 4'b1111; tick();
    chk("rot3_hold", 32'(gnta), 32'h8);
    reqa = 4'b0111; tick();
    chk("rot_wrap", 32'(gnta), 32'h1);
    chk("rot_wrap_idx", 32'(ia), 32'h0);
    reqa = 4'b0000; tick();
    chk("a_idle", 32'(gnta), 32'h0);

    // hold limit 3 alternating owners
    seq_h = '{4'h1, 4'h1, 4'h1,
              4'h4, 4'h4, 4'h4,
              4'h1, 4'h1, 4'h1};
    reqb = 4'b0101;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("limit%0d", i),
          32'(gntb), 32'(seq_h[i]));
    end

    // sole owner not preempted
    reqb = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sole%0d", i), 32'(gntb), 32'h2);
    end
    reqb = 4'b0000; tick();
    chk("sole_off_gnt", 32'(gntb), 32'h0);
    chk("sole_off_valid", 32'(vb), 32'h0);
    chk("sole_off_idx", 32'(ib), 32'h1);

    // wrap from idx 3 and mask
    reqb = 4'b1000; tick();
    chk("wrap_own3", 32'(gntb), 32'h8);
    reqb = 4'b0110; tick();
    chk("wrap_low", 32'(gntb), 32'h2);
    reqb = 4'b0100; tick();
    chk("wrap_next", 32'(gntb), 32'h4);
    chk("wrap_next_idx", 32'(ib), 32'h2);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gntb), 32'h0);
    chk("arst_valid", 32'(vb), 32'h0);
    reqb = 4'b1100;
    #1;
    rst = 1'b0;
    tick();
    chk("arst_after", 32'(gntb), 32'h4);
    chk("arst_after_idx", 32'(ib), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
